dvi_frame_reader: RTL and testbench
===================================

Name: dvi_frame_reader

Overview:
- Pixel-fetch stage between the SSRAM arbiter's DVI port and the DVI output encoder.
- On a start pulse, issued when DIBR finishes, it reads one 640x480 RGB565 frame out of SSRAM through the arbiter's DVI interface. Reads are in raster order.
- Fetched words are buffered in a small FIFO and presented as a valid/ready pixel stream with start-of-frame and end-of-line markers.
- It pulses finish to the arbiter once the last SSRAM read has been captured, so the arbiter can return to IDLE (buffer clear) while the FIFO drains.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- FRAME_BASE, 20'd0, SSRAM word address of pixel (0,0)
- RD_LAT, 2, cycles from address/oe_n presented to data sampled (minimum 1)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, must be greater than RD_LAT)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse: begin a frame fetch
- o_dvi_sram_addr  out  20  word address to the arbiter's DVI port
- io_dvi_sram_data  inout  16  read data from the arbiter; this block never drives it (always high-Z)
- o_dvi_sram_we_n  out  1  tied 1 (read only)
- o_dvi_sram_oe_n  out  1  0 while a read is issued
- o_dvi_finish  out  1  one-cycle pulse: last SSRAM read captured
- o_pix_valid  out  1  pixel available
- i_pix_ready  in  1  sink accepts pixel
- o_pix_data  out  16  RGB565 pixel
- o_pix_sof  out  1  qualifies the first pixel of the frame
- o_pix_eol  out  1  qualifies the last pixel of each line
- o_busy  out  1  high from start until the FIFO is empty after the last read

Behaviour:
- Clock and reset: single clock domain `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - All counters and the FIFO are cleared.
  - o_dvi_sram_addr=0, o_dvi_sram_oe_n=1, o_dvi_sram_we_n=1.
  - o_dvi_finish=0, o_pix_valid=0, o_pix_sof=0, o_pix_eol=0, o_busy=0.
  - A reset mid-frame aborts the frame immediately; no finish pulse is generated.
- States:
  - IDLE: if i_start, go to FETCH. Issue counters are cleared to (x=0, y=0) and the address is set to FRAME_BASE.
  - FETCH: issue one read per cycle when credit is available, incrementing the address by 1.
    - Credit rule: FIFO count + in-flight reads < FIFO_DEPTH.
    - When the read for pixel H_ACTIVE*V_ACTIVE-1 is issued, go to WAIT.
  - WAIT: stop issuing (oe_n=1) and wait until the in-flight count reaches 0. Then pulse o_dvi_finish for 1 cycle and go to DRAIN.
  - DRAIN: stay until the FIFO is empty, then go to IDLE.
  - i_start is ignored outside IDLE.
- Read pipeline:
  - Issuing a read means driving addr with oe_n=0 for 1 cycle.
  - Data is sampled from io_dvi_sram_data exactly RD_LAT cycles later, using a valid shift register of length RD_LAT, and written into the FIFO.
  - Sampled words are never dropped; the credit rule guarantees FIFO space.
- Tags:
  - Each FIFO entry carries {sof, eol, data}, 18 bits.
  - sof=1 for x=0,y=0. eol=1 for x=H_ACTIVE-1.
  - Tags are computed at issue time and travel through the latency pipe.
- Counter wrap: x wraps to 0 at H_ACTIVE-1 and y increments at the same time. The address is 20-bit with no wrap; the largest address is FRAME_BASE+307199.
- Output handshake:
  - o_pix_valid = FIFO not empty. Data and tags come from the FIFO head (show-ahead).
  - A pop occurs when valid && ready.
  - While valid and not ready, data and tags are held stable.
- FIFO boundaries:
  - A simultaneous push and pop when full or empty is legal; the count is unchanged.
  - Pushes never overflow (enforced by credit). A pop while empty cannot occur.
- Busy: o_busy = state != IDLE.

Decomposition:
- Shared package gpu_pkg holds:
  - frame constants H_ACTIVE_DEF=640, V_ACTIVE_DEF=480, FRAME_WORDS=307200
  - the SSRAM address width constant (20)
  - the reader state encoding (IDLE=0, FETCH=1, WAIT=2, DRAIN=3)
- One sub-module, pixel_fifo: synchronous, show-ahead, parameterised width/depth, providing full, empty and count. It is reused by later output stages.

Test Plan:
- Reset then i_start, with i_pix_ready held 1 and the SSRAM model returning data=addr[15:0]:
  - first read at addr 0 one cycle after start
  - o_pix_data sequence 0,1,2,...; 307200 pixels total
  - o_pix_sof only on the first pixel; o_pix_eol on pixels 639, 1279, ...
  - exactly one o_dvi_finish pulse, in the cycle after the last in-flight read completes
- i_pix_ready=0 after start: exactly FIFO_DEPTH=16 reads are issued, then oe_n stays 1. Raising ready resumes issue with no lost or duplicated pixel (data continuity checked).
- Random ready pattern (50%) over a frame:
  - no FIFO overflow
  - data held stable while valid && !ready
  - eol count = 480; pixel count = 307200
- FRAME_BASE=20'd307200: first address 307200, last address 614399, finish pulses once.
- Assert rst at pixel 1000 mid-FETCH: all outputs return to reset values asynchronously, no finish pulse. A subsequent i_start restarts at FRAME_BASE with sof on the first pixel.
- A second i_start pulse during FETCH and during DRAIN is ignored: the address sequence is unaffected and a single finish is produced.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU output path: frame geometry, SSRAM address width,
// the frame-reader state encoding and the tagged pixel word carried through the pixel FIFOs.
package gpu_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int FRAME_WORDS  = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int SRAM_AW      = 20;
    localparam int PIX_W        = 16;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_WAIT  = 2'd2,
        RD_DRAIN = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } pix_word_t;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO with count: head visible the cycle after a push, pop on i_pop.
// Push and pop together are accepted when full or empty (empty case passes i_data straight through).
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A pop only lands on an empty FIFO when a push arrives in the same cycle.
    assign w_push = i_push && (!o_full || i_pop);
    assign w_pop  = i_pop && (!o_empty || i_push);

    assign o_data = o_empty ? i_data : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dvi_frame_reader.sv
// Fetches one raster frame from SSRAM into a tagged valid/ready pixel stream; words arrive RD_LAT
// cycles after issue. Issue stalls on FIFO credit, so a stalled sink halts reads without loss.
module dvi_frame_reader
    import gpu_pkg::*;
#(
    parameter int                 H_ACTIVE   = H_ACTIVE_DEF,
    parameter int                 V_ACTIVE   = V_ACTIVE_DEF,
    parameter logic [SRAM_AW-1:0] FRAME_BASE = '0,
    parameter int                 RD_LAT     = 2,
    parameter int                 FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    output logic [SRAM_AW-1:0]   o_dvi_sram_addr,
    inout  wire  [PIX_W-1:0]     io_dvi_sram_data,
    output logic                 o_dvi_sram_we_n,
    output logic                 o_dvi_sram_oe_n,
    output logic                 o_dvi_finish,
    output logic                 o_pix_valid,
    input  logic                 i_pix_ready,
    output logic [PIX_W-1:0]     o_pix_data,
    output logic                 o_pix_sof,
    output logic                 o_pix_eol,
    output logic                 o_busy
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    rd_state_t          r_state;
    rd_state_t          w_next_state;
    logic [SRAM_AW-1:0] r_addr;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [RD_LAT-1:0]  r_vpipe;
    logic [RD_LAT-1:0]  r_sof_pipe;
    logic [RD_LAT-1:0]  r_eol_pipe;
    logic [IW-1:0]      w_inflight;
    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_credit;
    logic               w_issue;
    logic               w_last_pix;
    logic               w_push;
    logic               w_pop;
    pix_word_t          w_push_word;
    pix_word_t          w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + IW'(r_vpipe[i]);
        end
    end

    // Every word already in flight must have a FIFO slot reserved before another read goes out.
    assign w_credit   = !w_fifo_full &&
                        ((OW'(w_fifo_count) + OW'(w_inflight)) < OW'(FIFO_DEPTH));
    assign w_issue    = (r_state == RD_FETCH) && w_credit;
    assign w_last_pix = (r_x == XW'(H_ACTIVE - 1)) && (r_y == YW'(V_ACTIVE - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RD_IDLE:  if (i_start)                w_next_state = RD_FETCH;
            RD_FETCH: if (w_issue && w_last_pix)  w_next_state = RD_WAIT;
            RD_WAIT:  if (w_inflight == '0)       w_next_state = RD_DRAIN;
            RD_DRAIN: if (w_fifo_empty)           w_next_state = RD_IDLE;
            default:                              w_next_state = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RD_IDLE;
            r_addr     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_vpipe    <= '0;
            r_sof_pipe <= '0;
            r_eol_pipe <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == RD_IDLE && i_start) begin
                r_addr <= FRAME_BASE;
                r_x    <= '0;
                r_y    <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + 1'b1;
                if (r_x == XW'(H_ACTIVE - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            // Tags ride alongside the read-valid bit so they meet their data word at the FIFO.
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vpipe[i]    <= r_vpipe[i-1];
                r_sof_pipe[i] <= r_sof_pipe[i-1];
                r_eol_pipe[i] <= r_eol_pipe[i-1];
            end
            r_vpipe[0]    <= w_issue;
            r_sof_pipe[0] <= w_issue && (r_x == '0) && (r_y == '0);
            r_eol_pipe[0] <= w_issue && (r_x == XW'(H_ACTIVE - 1));
        end
    end

    assign w_push           = r_vpipe[RD_LAT-1];
    assign w_push_word.sof  = r_sof_pipe[RD_LAT-1];
    assign w_push_word.eol  = r_eol_pipe[RD_LAT-1];
    assign w_push_word.data = io_dvi_sram_data;

    pixel_fifo #(
        .WIDTH ($bits(pix_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_pop = o_pix_valid && i_pix_ready;

    assign o_dvi_sram_addr = r_addr;
    assign o_dvi_sram_we_n = 1'b1;
    assign o_dvi_sram_oe_n = !w_issue;
    assign o_dvi_finish    = (r_state == RD_WAIT) && (w_inflight == '0);
    assign o_pix_valid     = !w_fifo_empty;
    assign o_pix_data      = w_head.data;
    assign o_pix_sof       = o_pix_valid && w_head.sof;
    assign o_pix_eol       = o_pix_valid && w_head.eol;
    assign o_busy          = (r_state != RD_IDLE);

endmodule

// File: tb/tb_dvi_frame_reader.sv
// Bench for dvi_frame_reader on a reduced 16x6 frame at a high base address, with an SSRAM model
// returning addr[15:0] after RD_LAT cycles and a raster-order reference for the pixel stream.
module tb_dvi_frame_reader;

    localparam int          H      = 16;
    localparam int          V      = 6;
    localparam int          N      = H * V;
    localparam int          RD_LAT = 2;
    localparam int          DEPTH  = 16;
    localparam logic [19:0] BASE   = 20'd307200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_pix_ready = 1'b0;
    logic [19:0] o_dvi_sram_addr;
    wire  [15:0] sram_data;
    logic        o_dvi_sram_we_n;
    logic        o_dvi_sram_oe_n;
    logic        o_dvi_finish;
    logic        o_pix_valid;
    logic [15:0] o_pix_data;
    logic        o_pix_sof;
    logic        o_pix_eol;
    logic        o_busy;

    always #5 clk = ~clk;

    // SSRAM: the word for the address presented in cycle c is on the bus in cycle c+RD_LAT.
    logic [19:0] sram_pipe [RD_LAT];
    always @(posedge clk) begin
        sram_pipe[0] <= o_dvi_sram_addr;
        for (int i = 1; i < RD_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign sram_data = sram_pipe[RD_LAT-1][15:0];

    dvi_frame_reader #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FRAME_BASE (BASE),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .o_dvi_sram_addr  (o_dvi_sram_addr),
        .io_dvi_sram_data (sram_data),
        .o_dvi_sram_we_n  (o_dvi_sram_we_n),
        .o_dvi_sram_oe_n  (o_dvi_sram_oe_n),
        .o_dvi_finish     (o_dvi_finish),
        .o_pix_valid      (o_pix_valid),
        .i_pix_ready      (i_pix_ready),
        .o_pix_data       (o_pix_data),
        .o_pix_sof        (o_pix_sof),
        .o_pix_eol        (o_pix_eol),
        .o_busy           (o_busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc, last_issue_cyc;
    int          n_issued, n_popped, n_eol, n_finish;
    int          mode;
    logic        pend_start = 1'b0;
    logic        hold_pend;
    logic [17:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int idx);
        return 16'(32'(BASE) + 32'(idx));
    endfunction

    task automatic clear_model();
        n_issued = 0; n_popped = 0; n_eol = 0; n_finish = 0;
        last_issue_cyc = -100; hold_pend = 1'b0; held = '0;
    endtask

    task automatic set_ready();
        case (mode)
            0:       i_pix_ready = 1'b1;
            1:       i_pix_ready = 1'($urandom_range(0, 1));
            default: i_pix_ready = (cyc - start_cyc >= 40);
        endcase
    endtask

    task automatic sample();
        if (!o_dvi_sram_oe_n) begin
            check("rd_in_frame", 32'(n_issued < N), 32'd1);
            check("rd_addr", 32'(o_dvi_sram_addr), 32'(BASE) + 32'(n_issued));
            check("rd_we_n", 32'(o_dvi_sram_we_n), 32'd1);
            if (n_issued == 0) check("first_rd_delay", 32'(cyc - start_cyc), 32'd1);
            n_issued++;
            check("credit", 32'(n_issued - n_popped <= DEPTH), 32'd1);
            if (n_issued == N) last_issue_cyc = cyc;
        end
        if (hold_pend) begin
            check("hold_valid", 32'(o_pix_valid), 32'd1);
            check("hold_word", 32'({o_pix_sof, o_pix_eol, o_pix_data}), 32'(held));
        end
        if (o_pix_valid && i_pix_ready) begin
            check("pix_data", 32'(o_pix_data), 32'(exp_pix(n_popped)));
            check("pix_sof", 32'(o_pix_sof), 32'(n_popped == 0));
            check("pix_eol", 32'(o_pix_eol), 32'(n_popped % H == H - 1));
            n_eol += int'(o_pix_eol);
            n_popped++;
        end
        hold_pend = o_pix_valid && !i_pix_ready;
        held      = {o_pix_sof, o_pix_eol, o_pix_data};
        if (o_dvi_finish) begin
            n_finish++;
            check("finish_cycle", 32'(cyc), 32'(last_issue_cyc + RD_LAT + 1));
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        i_start    = pend_start;
        pend_start = 1'b0;
        set_ready();
    endtask

    task automatic check_reset_outputs();
        check("rst_addr", 32'(o_dvi_sram_addr), 32'd0);
        check("rst_oe_n", 32'(o_dvi_sram_oe_n), 32'd1);
        check("rst_we_n", 32'(o_dvi_sram_we_n), 32'd1);
        check("rst_finish", 32'(o_dvi_finish), 32'd0);
        check("rst_valid", 32'(o_pix_valid), 32'd0);
        check("rst_sof", 32'(o_pix_sof), 32'd0);
        check("rst_eol", 32'(o_pix_eol), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic run_frame(input int m, input bit extra_starts);
        bit done = 1'b0;
        bit kick_fetch = 1'b0;
        bit kick_drain = 1'b0;
        clear_model();
        mode      = m;
        start_cyc = cyc;
        set_ready();
        i_start   = 1'b1;
        for (int k = 0; k < 4000 && !done; k++) begin
            if (m == 2 && cyc - start_cyc == 40) check("stall_issues", 32'(n_issued), 32'(DEPTH));
            if (extra_starts && !kick_fetch && n_issued == N / 3) begin
                pend_start = 1'b1; kick_fetch = 1'b1;
            end
            if (extra_starts && !kick_drain && n_finish == 1) begin
                pend_start = 1'b1; kick_drain = 1'b1;
            end
            step();
            if (k == 0) check("busy_after_start", 32'(o_busy), 32'd1);
            if (n_popped == N && n_finish == 1 && !o_busy) done = 1'b1;
        end
        check("frame_done", 32'(done), 32'd1);
        repeat (6) step();
        check("pix_count", 32'(n_popped), 32'(N));
        check("eol_count", 32'(n_eol), 32'(V));
        check("rd_count", 32'(n_issued), 32'(N));
        check("finish_count", 32'(n_finish), 32'd1);
        check("busy_end", 32'(o_busy), 32'd0);
    endtask

    initial begin
        clear_model();
        mode = 0;
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_frame(0, 1'b0);
        run_frame(2, 1'b0);
        run_frame(1, 1'b1);

        // Abort a frame mid-fetch with an asynchronous reset.
        clear_model();
        mode      = 1;
        start_cyc = cyc;
        set_ready();
        i_start   = 1'b1;
        for (int k = 0; k < 2000 && n_popped < 40; k++) step();
        check("abort_reached", 32'(n_popped >= 40), 32'd1);
        check("abort_mid_fetch", 32'(n_issued < N), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        step();
        check("abort_no_finish", 32'(n_finish), 32'd0);
        rst = 1'b0;
        step();
        run_frame(1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
